fib_checker: RTL and testbench
==============================

FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001 SHALL have parameter W, default 32, sample width in bits.
REQ-002 SHALL have parameter N, default 100, number of terms per sequence (N >= 3).
REQ-003 SHALL have localparam IW = clog2(N+1), the term-index and error-count width (7 at defaults).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  pulse; aborts any check in progress and re-arms for a new sequence.
- en  in  1  sample strobe; x is valid this cycle.
- x  in  W  received term.
- busy  out  1  check in progress.
- done  out  1  sequence complete, sticky.
- pass  out  1  done with zero mismatches, sticky.
- err  out  1  at least one mismatch seen, sticky.
- err_idx  out  IW  index of the first mismatching term.
- err_cnt  out  IW  number of mismatching terms.
- exp  out  W  expected value of the next term.

Function
REQ-006 SHALL check terms against F(0)=0, F(1)=1, F(k)=(F(k-1)+F(k-2)) mod 2^W, for k = 0..N-1.
REQ-007 SHALL implement FSM states IDLE, RUN, PASS and FAIL; reset state is IDLE.
REQ-008 IDLE: the first en moves the FSM to RUN. Term 0 is compared on that same edge.
REQ-009 RUN: each en compares x with exp and advances the index.
REQ-010 When the term with index N-1 is accepted, the FSM SHALL move to PASS if err_cnt is 0 after that comparison, otherwise to FAIL.
REQ-011 All outputs SHALL be registered. The verdict SHALL be visible the cycle after the last accepted en.
REQ-012 In PASS and FAIL, en SHALL be ignored and all outputs held until start or reset.
REQ-013 start SHALL clear index, err, err_idx, err_cnt, done and pass, set exp=0, and return to IDLE.
REQ-014 start together with en in the same cycle: start wins. The sample is then accepted as term 0 with state freshly cleared, and the FSM enters RUN.
REQ-015 A cycle with en=0 SHALL leave all state unchanged; gaps between samples are legal at any length.
REQ-016 On the first mismatch, err_idx SHALL latch the index. err_idx is unchanged by later mismatches.
REQ-017 err_cnt SHALL increment once per mismatching term and never wrap (max N <= 2^IW-1).
REQ-018 The adder SHALL be W bits wide; the carry out is discarded (wrap-around is expected behaviour, not an error).
REQ-019 busy SHALL be 1 exactly in RUN. done SHALL be 1 in PASS and FAIL. pass SHALL be 1 only in PASS.

Reset
REQ-020 With rst=0 at a clock edge: FSM=IDLE, and busy, done, pass, err, err_idx, err_cnt, exp are all 0.
REQ-021 Reset mid-sequence SHALL discard all progress. en sampled during reset is ignored.

Configuration
REQ-022 Macro FIB_CHECKER_RESYNC_EN selects how the expected sequence recovers after a mismatch.
- Defined: after any term, the two history registers SHALL load the received x, not the expected value. Each term is then checked only against the recurrence of the two previously received terms, so one corrupted term yields at most 3 mismatches.
- Undefined: the history registers SHALL always follow the golden sequence, independent of x.

Structure
REQ-023 Package fib_pkg SHALL hold the FSM state enum, default W and N, and the IW computation function.
REQ-024 Sub-module fib_next SHALL hold the two history registers and the W-bit adder. It has load/advance/clear inputs and drives exp.
REQ-025 The top level SHALL hold the FSM, index counter, compare logic and error bookkeeping.

Verification
REQ-026 After reset, feed the 100 golden terms back-to-back -> done=1 and pass=1 the cycle after term 99, err_cnt=0.
REQ-027 Golden stream with x forced to 2971215074 at index 47 -> err=1, err_idx=47, FAIL.
- Resync undefined: err_cnt=1.
- Resync defined: err_cnt=3.
REQ-028 Golden stream at W=32 -> term 48 accepted as 512559680 (wrapped value), no error.
REQ-029 Same golden stream with en held low for 5 cycles between every pair of terms -> identical PASS result, busy=1 throughout the gaps.
REQ-030 Abort cases:
- start asserted at index 30 together with en, x=0 -> index restarts with this sample as term 0; full sequence then passes.
- rst=0 at index 60 -> all outputs 0 next cycle.
REQ-031 Extra en after PASS with x=7 -> outputs unchanged.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared FSM state type, default sizing and index-width helper for the Fibonacci checker.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam int DEF_W = 32;
  localparam int DEF_N = 100;

  function automatic int calc_iw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fib_next.sv
// Expected-term generator: two history registers and a W-bit wrapping adder.
// load steps from the received sample, advance steps the golden recurrence, clear re-seeds.
module fib_next #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] x,
  output logic [W-1:0] exp
);

  logic [W-1:0] r_prev;
  logic [W-1:0] r_cur;
  logic [W-1:0] w_prev_base;
  logic [W-1:0] w_cur_base;

  // Seeding r_prev with F(-1)=1 makes the term after F(0)=0 come out as 1.
  assign w_prev_base = clear ? W'(1) : r_prev;
  assign w_cur_base  = clear ? '0    : r_cur;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= W'(1);
      r_cur  <= '0;
    end else if (load) begin
      r_prev <= x;
      r_cur  <= x + w_prev_base;
    end else if (advance) begin
      r_prev <= w_cur_base;
      r_cur  <= w_cur_base + w_prev_base;
    end else if (clear) begin
      r_prev <= W'(1);
      r_cur  <= '0;
    end
  end

  assign exp = r_cur;

endmodule

// File: rtl/fib_checker.sv
// Fibonacci stream checker: FSM, term index, compare and sticky error bookkeeping.
// Define FIB_CHECKER_RESYNC_EN to re-seed the expected sequence from received samples.
module fib_checker
  import fib_pkg::*;
#(
  parameter  int W  = DEF_W,
  parameter  int N  = DEF_N,
  localparam int IW = calc_iw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic [W-1:0]  x,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err,
  output logic [IW-1:0] err_idx,
  output logic [IW-1:0] err_cnt,
  output logic [W-1:0]  exp
);

  state_t        r_state;
  state_t        w_state_base;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_err_idx;
  logic [IW-1:0] r_err_cnt;
  logic          r_err;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [IW-1:0] w_idx_base;
  logic [IW-1:0] w_cnt_base;
  logic [IW-1:0] w_cnt_nxt;
  logic          w_err_base;
  logic [W-1:0]  w_exp_base;
  logic          w_acc;
  logic          w_mis;
  logic          w_last;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;
  logic          w_load;
  logic          w_adv;

  function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + IW'(1);
    return v;
  endfunction

  // start wipes the sequence first, so a same-cycle sample is judged as term 0.
  assign w_state_base = start ? ST_IDLE : r_state;
  assign w_idx_base   = start ? '0 : r_idx;
  assign w_cnt_base   = start ? '0 : r_err_cnt;
  assign w_err_base   = start ? 1'b0 : r_err;
  assign w_exp_base   = start ? '0 : exp;

  assign w_acc     = en && ((w_state_base == ST_IDLE) || (w_state_base == ST_RUN));
  assign w_mis     = w_acc && (x != w_exp_base);
  assign w_last    = (w_idx_base == IW'(N - 1));
  assign w_cnt_nxt = sat_inc(w_cnt_base, w_mis);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state_base;
    if (w_acc) begin
      if (w_last) w_state_nxt = (w_cnt_nxt == '0) ? ST_PASS : ST_FAIL;
      else        w_state_nxt = ST_RUN;
    end
  end

  // Status flags are decoded from the next state so they leave flops directly.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
    w_pass_nxt = (w_state_nxt == ST_PASS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_err_cnt <= '0;
    end else begin
      if (start) begin
        r_idx     <= '0;
        r_err     <= 1'b0;
        r_err_idx <= '0;
        r_err_cnt <= '0;
      end
      if (w_acc) begin
        r_idx     <= w_idx_base + IW'(1);
        r_err_cnt <= w_cnt_nxt;
        if (w_mis && !w_err_base) begin
          r_err     <= 1'b1;
          r_err_idx <= w_idx_base;
        end
      end
    end
  end

`ifdef FIB_CHECKER_RESYNC_EN
  assign w_load = w_acc;
  assign w_adv  = 1'b0;
`else
  assign w_load = 1'b0;
  assign w_adv  = w_acc;
`endif

  fib_next #(.W(W)) u_next (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .advance (w_adv),
    .load    (w_load),
    .x       (x),
    .exp     (exp)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err     = r_err;
  assign err_idx = r_err_idx;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fib_checker.sv
// Randomized and directed bench for fib_checker against a sequence-level reference model.
module tb_fib_checker;

  localparam int W  = 32;
  localparam int N  = 100;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  x = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          err;
  logic [IW-1:0] err_idx;
  logic [IW-1:0] err_cnt;
  logic [W-1:0]  exp;

  fib_checker #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err     (err),
    .err_idx (err_idx),
    .err_cnt (err_cnt),
    .exp     (exp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: verdict state 0=idle 1=run 2=pass 3=fail, plus received terms.
  logic [W-1:0] fib [0:N];
  int           m_state;
  int           m_idx;
  int           m_cnt;
  int           m_eidx;
  bit           m_err;
  logic [W-1:0] m_rx [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] model_exp(input int k);
`ifdef FIB_CHECKER_RESYNC_EN
    if (k == 0) return '0;
    if (k == 1) return m_rx[0] + 32'd1;
    return m_rx[k-1] + m_rx[k-2];
`else
    return fib[k];
`endif
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_idx   = 0;
    m_cnt   = 0;
    m_eidx  = 0;
    m_err   = 1'b0;
    m_rx.delete();
  endtask

  task automatic model_step(input logic r, input logic s, input logic e, input logic [W-1:0] xv);
    if (!r) begin
      model_clear();
      return;
    end
    if (s) model_clear();
    if (e && (m_state < 2)) begin
      if (xv != model_exp(m_idx)) begin
        if (!m_err) begin
          m_err  = 1'b1;
          m_eidx = m_idx;
        end
        m_cnt++;
      end
      m_rx.push_back(xv);
      m_idx++;
      m_state = (m_idx == N) ? ((m_cnt == 0) ? 2 : 3) : 1;
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_state == 1);
    chk("done", done, m_state >= 2);
    chk("pass", pass, m_state == 2);
    chk("err", err, m_err);
    chk("err_idx", err_idx, m_eidx);
    chk("err_cnt", err_cnt, m_cnt);
    chk("exp", exp, model_exp(m_idx));
  endtask

  task automatic cycle(input logic r, input logic s, input logic e, input logic [W-1:0] xv);
    rst = r; start = s; en = e; x = xv;
    @(posedge clk);
    model_step(r, s, e, xv);
    #1;
    check_outputs();
  endtask

  task automatic feed(input int from, input int to, input int bad_idx,
                      input logic [W-1:0] bad_val, input int gap, input bit chk48);
    for (int k = from; k <= to; k++) begin
      if (chk48 && (k == 48)) chk("wrap48", exp, 32'd512559680);
      cycle(1'b1, 1'b0, 1'b1, (k == bad_idx) ? bad_val : fib[k]);
      if (k != to) repeat (gap) cycle(1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    longint unsigned s;
    fib[0] = '0;
    fib[1] = 32'd1;
    for (int k = 2; k <= N; k++) begin
      s = (longint'(fib[k-1]) + longint'(fib[k-2])) % 64'h1_0000_0000;
      fib[k] = s[31:0];
    end
    model_clear();

    repeat (3) cycle(1'b0, 1'b0, 1'b1, 32'd5);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Golden stream, back-to-back, including the wrapped term 48.
    feed(0, N-1, -1, '0, 0, 1'b1);
    chk("t1_pass", pass, 1'b1);
    chk("t1_cnt", err_cnt, 0);

    // Single corrupted term at index 47.
    cycle(1'b1, 1'b1, 1'b0, '0);
    feed(0, N-1, 47, 32'd2971215074, 0, 1'b0);
    chk("t2_err", err, 1'b1);
    chk("t2_idx", err_idx, 47);
    chk("t2_pass", pass, 1'b0);
`ifdef FIB_CHECKER_RESYNC_EN
    chk("t2_cnt", err_cnt, 3);
`else
    chk("t2_cnt", err_cnt, 1);
`endif

    // Five idle cycles between every pair of terms.
    cycle(1'b1, 1'b1, 1'b0, '0);
    feed(0, N-1, -1, '0, 5, 1'b0);
    chk("t3_pass", pass, 1'b1);

    // start together with en at index 30 restarts the sequence.
    cycle(1'b1, 1'b1, 1'b0, '0);
    feed(0, 29, -1, '0, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, '0);
    chk("t4_restart_idx", exp, 32'd1);
    feed(1, N-1, -1, '0, 0, 1'b0);
    chk("t4_pass", pass, 1'b1);

    // Reset at index 60 discards everything, including the en in that cycle.
    cycle(1'b1, 1'b1, 1'b0, '0);
    feed(0, 59, -1, '0, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, fib[60]);
    chk("t5_busy", busy, 1'b0);
    chk("t5_exp", exp, 0);
    feed(0, N-1, -1, '0, 0, 1'b0);
    chk("t5_pass", pass, 1'b1);

    // Extra samples after PASS are ignored.
    cycle(1'b1, 1'b0, 1'b1, 32'd7);
    cycle(1'b1, 1'b0, 1'b1, 32'd7);
    chk("t6_pass", pass, 1'b1);
    chk("t6_err", err, 1'b0);

    // Random gaps, random corruption, occasional restart.
    for (int seq = 0; seq < 6; seq++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      for (int k = 0; k < N; k++) begin
        logic [W-1:0] xv;
        xv = ($urandom_range(0, 24) == 0) ? $urandom : fib[m_idx];
        repeat ($urandom_range(0, 2)) cycle(1'b1, 1'b0, 1'b0, $urandom);
        if ($urandom_range(0, 299) == 0) cycle(1'b1, 1'b1, 1'b1, '0);
        else                             cycle(1'b1, 1'b0, 1'b1, xv);
      end
      while (m_state < 2) cycle(1'b1, 1'b0, 1'b1, fib[m_idx]);
      chk("rnd_done", done, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
